// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD motion-estimation datapath.
// Row geometry, feeder state encoding and the compute_sad lane width.
package sad_pkg;
  localparam int PIX_W       = 8;
  localparam int PIX_PER_ROW = 8;
  localparam int ROW_W       = PIX_W * PIX_PER_ROW;
  localparam int SAD_LANE_W  = 12;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } feed_state_t;
endpackage

// File: rtl/sad_window_feeder_if.sv
// Row-input streams and window-output stream of the SAD window feeder.
// slave is the feeder side; master is the producer/consumer side.
interface sad_window_feeder_if #(
  parameter int CNT_W = 4
);
  import sad_pkg::*;

  logic             cur_valid;
  row_t             cur_row;
  logic             cur_ready;
  logic             org_valid;
  row_t             org_row;
  logic             org_ready;
  logic             win_valid;
  logic             win_ready;
  row_t             cur_upper_pix;
  row_t             cur_middle_pix;
  row_t             cur_lower_pix;
  row_t             org_pix;
  logic [CNT_W-1:0] win_row;
  logic             win_last;

  modport slave (
    input  cur_valid, cur_row, org_valid, org_row, win_ready,
    output cur_ready, org_ready, win_valid, cur_upper_pix, cur_middle_pix,
           cur_lower_pix, org_pix, win_row, win_last
  );

  modport master (
    output cur_valid, cur_row, org_valid, org_row, win_ready,
    input  cur_ready, org_ready, win_valid, cur_upper_pix, cur_middle_pix,
           cur_lower_pix, org_pix, win_row, win_last
  );
endinterface

// File: rtl/sad_row_shift3.sv
// Three-row window shift register with staging registers for block priming.
// Staged rows only enter the live window on the first shift of a block (prime).
module sad_row_shift3
  import sad_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load_mid,
  input  logic load_low,
  input  logic shift,
  input  logic prime,
  input  row_t row_in,
  output row_t upper,
  output row_t middle,
  output row_t lower
);
  row_t stage_mid;
  row_t stage_low;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_mid <= '0;
      stage_low <= '0;
      upper     <= '0;
      middle    <= '0;
      lower     <= '0;
    end else begin
      if (load_mid) stage_mid <= row_in;
      if (load_low) stage_low <= row_in;
      // Staging keeps a held final window of the previous block intact.
      if (shift) begin
        upper  <= prime ? stage_mid : middle;
        middle <= prime ? stage_low : lower;
        lower  <= row_in;
      end
    end
  end
endmodule

// File: rtl/sad_window_feeder.sv
// Pairs three-row current windows with org rows for compute_sad; 1-clock accept-to-valid.
// Stalled windows freeze outputs and drop both readies; cur/org are only taken as a pair.
module sad_window_feeder #(
  parameter int BLK_ROWS = 8,
  parameter int ROW_W    = 64,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                blk_abort,
  sad_window_feeder_if.slave  bus
);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(BLK_ROWS - 1);

  sad_pkg::feed_state_t state;
  logic                 fill_cnt;
  logic [CNT_W-1:0]     row_cnt;
  logic                 live;
  logic                 win_valid_q;
  logic [CNT_W-1:0]     win_row_q;
  logic                 win_last_q;
  logic [ROW_W-1:0]     org_pix_q;
  logic                 slot_free;
  logic                 fill_take;
  logic                 run_take;
  logic                 pair_ok;

  assign slot_free = !win_valid_q || bus.win_ready;
  assign pair_ok   = slot_free && bus.cur_valid && bus.org_valid;
  // live holds the readies low until the first clock after reset release.
  assign fill_take = live && !blk_abort && (state == sad_pkg::ST_FILL) && bus.cur_valid;
  assign run_take  = live && !blk_abort && (state == sad_pkg::ST_RUN) && pair_ok;

  assign bus.cur_ready = live && !blk_abort &&
                         ((state == sad_pkg::ST_FILL) || pair_ok);
  assign bus.org_ready = live && !blk_abort && (state == sad_pkg::ST_RUN) && pair_ok;
  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_last  = win_last_q;
  assign bus.org_pix   = org_pix_q;

  sad_row_shift3 u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_mid (fill_take && !fill_cnt),
    .load_low (fill_take && fill_cnt),
    .shift    (run_take),
    .prime    (row_cnt == '0),
    .row_in   (bus.cur_row),
    .upper    (bus.cur_upper_pix),
    .middle   (bus.cur_middle_pix),
    .lower    (bus.cur_lower_pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= sad_pkg::ST_FILL;
      fill_cnt    <= 1'b0;
      row_cnt     <= '0;
      live        <= 1'b0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_last_q  <= 1'b0;
      org_pix_q   <= '0;
    end else begin
      live <= 1'b1;
      if (blk_abort) begin
        state       <= sad_pkg::ST_FILL;
        fill_cnt    <= 1'b0;
        row_cnt     <= '0;
        win_valid_q <= 1'b0;
      end else begin
        if (run_take) begin
          org_pix_q   <= bus.org_row;
          win_row_q   <= row_cnt;
          win_last_q  <= (row_cnt == LAST_ROW);
          win_valid_q <= 1'b1;
          if (row_cnt == LAST_ROW) begin
            row_cnt  <= '0;
            fill_cnt <= 1'b0;
            state    <= sad_pkg::ST_FILL;
          end else begin
            row_cnt <= row_cnt + CNT_W'(1);
          end
        end else if (bus.win_ready) begin
          win_valid_q <= 1'b0;
        end
        if (fill_take) begin
          fill_cnt <= !fill_cnt;
          if (fill_cnt) state <= sad_pkg::ST_RUN;
        end
      end
    end
  end
endmodule

// File: doc/sad_window_feeder.md
Name: sad_window_feeder

Overview:
- Streaming front end for compute_sad. Takes current-frame rows and original-block rows as 64-bit words (8 pixels × 8 bits, pixel 0 in bits [7:0]).
- Builds the three-row current window (upper/middle/lower) and pairs it with the matching org row.
- Presents each window with a valid/ready handshake. compute_sad connects directly to the window/org outputs.
- Replaces file-driven stimulus with a synthesizable row sequencer for the motion-estimation datapath.

Parameters:
- BLK_ROWS, 8, org rows per block; each block consumes BLK_ROWS+2 cur rows.
- ROW_W, 64, row width in bits (8 pixels × 8 bits); fixed at 64 for compute_sad.
- CNT_W, 4, width of the row counter; must satisfy 2^CNT_W > BLK_ROWS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- blk_abort  in  1  synchronous abort of the current block; returns to FILL.
- cur_valid  in  1  cur_row valid.
- cur_row  in  64  current-frame row.
- cur_ready  out  1  cur_row accepted when cur_valid && cur_ready.
- org_valid  in  1  org_row valid.
- org_row  in  64  original-block row.
- org_ready  out  1  org_row accepted when org_valid && org_ready.
- win_valid  out  1  window outputs valid.
- win_ready  in  1  downstream accepts the window.
- cur_upper_pix  out  64  window row r-1.
- cur_middle_pix  out  64  window row r.
- cur_lower_pix  out  64  window row r+1.
- org_pix  out  64  org row r.
- win_row  out  CNT_W  index r of the presented window, 0..BLK_ROWS-1.
- win_last  out  1  presented window is row BLK_ROWS-1.

Behaviour:

Reset (rst_n low, asynchronous):
- State FILL, fill_cnt=0, row_cnt=0.
- All pixel registers 0, win_valid=0, win_row=0, win_last=0.
- cur_ready=0 and org_ready=0 while in reset.

Definitions:
- slot_free = !win_valid || win_ready.

FILL state (priming):
- cur_ready=1, org_ready=0.
- 1st accepted cur row -> cur_middle_pix. 2nd accepted cur row -> cur_lower_pix, then go to RUN.
- win_valid is forced to 0 on entry to FILL, except for an unconsumed final window of the previous block, which is held until win_ready.
- FILL loads do not disturb that held window: middle/lower staging uses shadow registers, copied into the live window at the first RUN accept.

RUN state:
- cur_ready = org_ready = slot_free && cur_valid && org_valid. Cur and org rows are consumed in the same cycle only; neither is taken alone.
- On accept: upper<=middle, middle<=lower, lower<=cur_row, org_pix<=org_row, win_row<=row_cnt, win_last<=(row_cnt==BLK_ROWS-1), row_cnt++, win_valid<=1.
- If win_ready with no accept, win_valid<=0.
- Throughput is one window per clock when all parties stream. Latency is 1 clock from accept to win_valid.
- After the accept with row_cnt==BLK_ROWS-1: row_cnt<=0, fill_cnt<=0, go to FILL.

Backpressure:
- While win_valid && !win_ready, all window outputs are frozen and both ready outputs are 0.

blk_abort:
- Takes priority over every other event in the same cycle: any accept that cycle is ignored.
- Next state FILL, win_valid<=0, counters cleared. Pixel registers keep their values (don't-care).

Reset mid-block:
- Behaves identically to reset; no partial window survives.

Arithmetic:
- Counters wrap only through explicit clears; row_cnt never exceeds BLK_ROWS-1.

Decomposition:
- Shared package sad_pkg holds:
  - PIX_W=8, PIX_PER_ROW=8, ROW_W=64.
  - The state encoding (FILL, RUN).
  - The SAD lane width 12, for consumers of compute_sad.
- One natural sub-module: sad_row_shift3, the 3-deep row shift register with load-middle/load-lower/shift controls. The FSM, counters and handshake stay in the top level.

Test Plan:
1. Reset, then cur rows R0..R9 (R_k = all bytes k) and org rows O0..O7, all valid, win_ready=1.
   -> 8 windows on consecutive clocks. Window r has upper=R_r, middle=R_(r+1), lower=R_(r+2), org=O_r. win_last only on r=7. First win_valid 1 clock after first paired accept.
2. Same stimulus with win_ready held low 3 clocks at r=3.
   -> Outputs frozen, cur_ready=org_ready=0 during the stall. No row lost or duplicated; window 4 follows after release.
3. org_valid low while cur_valid high in RUN.
   -> No cur row consumed. cur_ready=0 until org_valid rises.
4. Two back-to-back blocks (20 cur, 16 org rows).
   -> 2 FILL cycles between blocks. Second block window 0 has upper=R10, org=O8. win_row restarts at 0.
5. blk_abort asserted at r=5 together with valid rows.
   -> Rows that cycle are not consumed. win_valid=0 next clock, state FILL. The next block starts correctly from fresh rows.
6. rst_n pulsed low asynchronously mid-block.
   -> All outputs 0 immediately. Clean restart in FILL after release.
